// File: rtl/aes_mix_pkg.sv
// aes_mix_pkg: shared GF(2^8) helpers and types for the MixColumns pipeline
// Provides the reduction constant, xtime, the per-beat mode encoding and the column type.
package aes_mix_pkg;
    localparam logic [7:0] GF_POLY = 8'h1b;
    typedef enum logic [1:0] {FWD = 2'd0, INV = 2'd1, BYP = 2'd2} mix_mode_t;
    // Element [3] sits at bits [31:24] and holds byte b0.
    typedef logic [3:0][7:0] col_t;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (GF_POLY & {8{a[7]}});
    endfunction
endpackage

// File: rtl/aes_mixcol_word.sv
// aes_mixcol_word: combinational single-column inverse pre-transform and forward mix
// Ports: inv_i/pre_i -> pre_o (pre-transformed when inv_i, else identity);
//        byp_i/mix_i -> mix_o (forward MixColumns of mix_i, or mix_i when byp_i).
module aes_mixcol_word
    import aes_mix_pkg::*;
(
    input  logic inv_i,
    input  col_t pre_i,
    output col_t pre_o,
    input  logic byp_i,
    input  col_t mix_i,
    output col_t mix_o
);
    logic [7:0] u, v, b0, b1, b2, b3, m0, m1, m2, m3;
    // InvMixColumns = MixColumns after multiplying b0/b2 and b1/b3 pairs by {04}.
    assign u = xtime(xtime(pre_i[3] ^ pre_i[1]));
    assign v = xtime(xtime(pre_i[2] ^ pre_i[0]));
    assign pre_o = inv_i ? {pre_i[3] ^ u, pre_i[2] ^ v, pre_i[1] ^ u, pre_i[0] ^ v} : pre_i;
    assign b0 = mix_i[3];
    assign b1 = mix_i[2];
    assign b2 = mix_i[1];
    assign b3 = mix_i[0];
    assign m0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    assign m1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
    assign m2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
    assign m3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
    assign mix_o = byp_i ? mix_i : {m0, m1, m2, m3};
endmodule

// File: rtl/aes_mixcol_pipe.sv
// aes_mixcol_pipe: pipelined AES MixColumns/InvMixColumns/bypass with valid/ready flow control
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_mode/in_tag beat input;
//        out_valid/out_ready/out_data/out_tag beat output. Column c at [32c+31:32c].
module aes_mixcol_pipe
    import aes_mix_pkg::*;
#(
    parameter int NCOL   = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*NCOL-1:0]   in_data,
    input  logic [1:0]           in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NCOL-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W = 32 * NCOL;
    col_t [NCOL-1:0] in_cols, pre, mix_src, mix;
    logic in_inv, in_byp, mix_byp;
    assign in_cols = in_data;
    assign in_inv  = in_mode == INV;
    // Reserved mode 3 shares bit 1 with bypass, so it bypasses too.
    assign in_byp  = in_mode[1];
    for (genvar c = 0; c < NCOL; c++) begin : g_col
        aes_mixcol_word u_word (
            .inv_i (in_inv),
            .pre_i (in_cols[c]),
            .pre_o (pre[c]),
            .byp_i (mix_byp),
            .mix_i (mix_src[c]),
            .mix_o (mix[c])
        );
    end
    if (STAGES == 2) begin : g_two
        logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s1_byp_q, s1_byp_d, s1_load, s2_load;
        col_t [NCOL-1:0] s1_data_q, s1_data_d;
        logic [W-1:0] s2_data_q, s2_data_d;
        logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
        assign s2_load = !s2_v_q || out_ready;
        assign s1_load = !s1_v_q || s2_load;
        always_comb begin
            s1_v_d    = s1_load ? in_valid : s1_v_q;
            s1_data_d = (s1_load && in_valid) ? pre : s1_data_q;
            s1_byp_d  = (s1_load && in_valid) ? in_byp : s1_byp_q;
            s1_tag_d  = (s1_load && in_valid) ? in_tag : s1_tag_q;
            s2_v_d    = s2_load ? s1_v_q : s2_v_q;
            s2_data_d = (s2_load && s1_v_q) ? mix : s2_data_q;
            s2_tag_d  = (s2_load && s1_v_q) ? s1_tag_q : s2_tag_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_v_q    <= 1'b0;
                s1_data_q <= '0;
                s1_byp_q  <= 1'b0;
                s1_tag_q  <= '0;
                s2_v_q    <= 1'b0;
                s2_data_q <= '0;
                s2_tag_q  <= '0;
            end else begin
                s1_v_q    <= s1_v_d;
                s1_data_q <= s1_data_d;
                s1_byp_q  <= s1_byp_d;
                s1_tag_q  <= s1_tag_d;
                s2_v_q    <= s2_v_d;
                s2_data_q <= s2_data_d;
                s2_tag_q  <= s2_tag_d;
            end
        end
        assign in_ready  = s1_load;
        assign mix_src   = s1_data_q;
        assign mix_byp   = s1_byp_q;
        assign out_valid = s2_v_q;
        assign out_data  = s2_data_q;
        assign out_tag   = s2_tag_q;
    end else begin : g_one
        logic v_q, v_d, load;
        logic [W-1:0] data_q, data_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        assign load = !v_q || out_ready;
        always_comb begin
            v_d    = load ? in_valid : v_q;
            data_d = (load && in_valid) ? mix : data_q;
            tag_d  = (load && in_valid) ? in_tag : tag_q;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q    <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
            end else begin
                v_q    <= v_d;
                data_q <= data_d;
                tag_q  <= tag_d;
            end
        end
        assign in_ready  = load;
        assign mix_src   = pre;
        assign mix_byp   = in_byp;
        assign out_valid = v_q;
        assign out_data  = data_q;
        assign out_tag   = tag_q;
    end
endmodule

// File: tb/tb_aes_mixcol_pipe.sv
// tb_aes_mixcol_pipe: directed self-checking bench for aes_mixcol_pipe
module tb_aes_mixcol_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [127:0] in_data = '0, out_data;
    logic [1:0] in_mode = '0;
    logic [3:0] in_tag = '0, out_tag;
    logic s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [31:0] s_in_data = '0, s_out_data;
    logic [1:0] s_in_mode = '0;
    logic [3:0] s_in_tag = '0, s_out_tag;
    int checks = 0;
    int failures = 0;
    localparam logic [127:0] VA  = 128'h2d26314c_01010101_f20a225c_db135345;
    localparam logic [127:0] VF  = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;
    localparam logic [127:0] VB  = 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc;
    localparam logic [127:0] VIB = 128'h2d26314c_d4d4d4d5_f20a225c_db135345;
    localparam logic [127:0] VC  = 128'hd4d4d4d5_c6c6c6c6_01010101_db135345;
    localparam logic [127:0] VFC = 128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc;
    localparam logic [127:0] VQ  = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] VP  = 128'h00ff00ff_deadbeef_12345678_c6c6c6c6;
    localparam logic [127:0] V1  = 128'h01010101_01010101_01010101_01010101;

    aes_mixcol_pipe #(.NCOL(4), .STAGES(2), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );
    aes_mixcol_pipe #(.NCOL(1), .STAGES(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_mode(s_in_mode), .in_tag(s_in_tag), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_tag(s_out_tag)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0 || out_tag !== '0) begin failures++; $display("FAIL rst_out_data got=%h/%h exp=0/0", out_data, out_tag); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_in_ready !== 1'b1) begin failures++; $display("FAIL rst_s1 got=%b/%h/%b exp=0/0/1", s_out_valid, s_out_data, s_in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        cyc();
        in_valid = 1'b1; in_data = VA; in_mode = 2'd0; in_tag = 4'd5;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fwd_in_ready got=%b exp=1", in_ready); end
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_early got=%b exp=0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== VF || out_tag !== 4'd5) begin failures++; $display("FAIL fwd_data got=%b %h t%h exp=1 %h t5", out_valid, out_data, out_tag, VF); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fwd_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_inverse();
        cyc();
        in_valid = 1'b1; in_data = VB; in_mode = 2'd1; in_tag = 4'd3;
        cyc();
        in_data = VA; in_mode = 2'd0; in_tag = 4'd4;
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== VIB || out_tag !== 4'd3) begin failures++; $display("FAIL inv_data got=%b %h t%h exp=1 %h t3", out_valid, out_data, out_tag, VIB); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== VF || out_tag !== 4'd4) begin failures++; $display("FAIL inv_next_fwd got=%b %h t%h exp=1 %h t4", out_valid, out_data, out_tag, VF); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inv_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        cyc();
        in_valid = 1'b1; in_data = VP; in_mode = 2'd2; in_tag = 4'd1;
        cyc();
        in_mode = 2'd3; in_tag = 4'd2;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL byp_early got=%b exp=0", out_valid); end
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== VP || out_tag !== 4'd1) begin failures++; $display("FAIL byp_mode2 got=%b %h t%h exp=1 %h t1", out_valid, out_data, out_tag, VP); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== VP || out_tag !== 4'd2) begin failures++; $display("FAIL byp_mode3 got=%b %h t%h exp=1 %h t2", out_valid, out_data, out_tag, VP); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL byp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [127:0] vin[6];
        logic [127:0] vexp[6];
        logic [1:0] vm[6];
        bit pat[4];
        int sent = 0, recv = 0, occ = 0;
        bit prev_stall = 1'b0;
        logic [127:0] prev_data = '0;
        logic [3:0] prev_tag = '0;
        bit in_fire, out_fire;
        vin = '{VA, VF, VC, VFC, VQ, VB};
        vexp = '{VF, VA, VFC, VC, VQ, VIB};
        vm = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 60 && recv < 6; t++) begin
            cyc();
            out_ready = pat[t % 4];
            in_valid = sent < 6;
            if (sent < 6) begin
                in_data = vin[sent]; in_mode = vm[sent]; in_tag = 4'(sent + 8);
            end
            #1;
            checks++; if (in_ready !== !(occ == 2 && !out_ready)) begin failures++; $display("FAIL bp_in_ready t=%0d got=%b exp=%b", t, in_ready, !(occ == 2 && !out_ready)); end
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin failures++; $display("FAIL bp_hold t=%0d got=%b %h t%h exp=1 %h t%h", t, out_valid, out_data, out_tag, prev_data, prev_tag); end
            end
            if (out_valid === 1'b1) begin
                checks++; if (out_data !== vexp[recv] || out_tag !== 4'(recv + 8)) begin failures++; $display("FAIL bp_order beat=%0d got=%h t%h exp=%h t%h", recv, out_data, out_tag, vexp[recv], 4'(recv + 8)); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_tag = out_tag;
            in_fire = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            occ += int'(in_fire) - int'(out_fire);
            sent += int'(in_fire);
            recv += int'(out_fire);
        end
        checks++; if (recv != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", recv); end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        cyc();
        in_valid = 1'b1; in_data = VA; in_mode = 2'd0; in_tag = 4'd6;
        cyc();
        in_data = VB; in_mode = 2'd1; in_tag = 4'd7;
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin failures++; $display("FAIL mid_async got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_data); end
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_release got=%b/%b exp=0/1", out_valid, in_ready); end
        in_valid = 1'b1; in_data = V1; in_mode = 2'd0; in_tag = 4'd9;
        cyc();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%b exp=0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_data !== V1 || out_tag !== 4'd9) begin failures++; $display("FAIL mid_after got=%b %h t%h exp=1 %h t9", out_valid, out_data, out_tag, V1); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_param_sweep();
        cyc();
        s_in_valid = 1'b1; s_in_data = 32'hdb135345; s_in_mode = 2'd0; s_in_tag = 4'd3;
        #1;
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL s1_in_ready got=%b exp=1", s_in_ready); end
        cyc();
        s_in_data = 32'h8e4da1bc; s_in_mode = 2'd1; s_in_tag = 4'd4;
        #1;
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h8e4da1bc || s_out_tag !== 4'd3) begin failures++; $display("FAIL s1_fwd got=%b %h t%h exp=1 8e4da1bc t3", s_out_valid, s_out_data, s_out_tag); end
        cyc();
        s_in_data = 32'h12345678; s_in_mode = 2'd2; s_in_tag = 4'd5;
        #1;
        checks++; if (s_in_ready !== 1'b1 || s_out_data !== 32'hdb135345 || s_out_tag !== 4'd4) begin failures++; $display("FAIL s1_inv got=%b %h t%h exp=1 db135345 t4", s_in_ready, s_out_data, s_out_tag); end
        cyc();
        s_in_data = 32'hc6c6c6c6; s_in_mode = 2'd0; s_in_tag = 4'd6;
        s_out_ready = 1'b0;
        #1;
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h12345678 || s_out_tag !== 4'd5) begin failures++; $display("FAIL s1_byp got=%b %h t%h exp=1 12345678 t5", s_out_valid, s_out_data, s_out_tag); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL s1_full got=%b exp=0", s_in_ready); end
        cyc();
        s_out_ready = 1'b1;
        #1;
        checks++; if (s_out_data !== 32'h12345678 || s_in_ready !== 1'b1) begin failures++; $display("FAIL s1_hold got=%h/%b exp=12345678/1", s_out_data, s_in_ready); end
        cyc();
        s_in_valid = 1'b0;
        #1;
        checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'hc6c6c6c6 || s_out_tag !== 4'd6) begin failures++; $display("FAIL s1_resume got=%b %h t%h exp=1 c6c6c6c6 t6", s_out_valid, s_out_data, s_out_tag); end
        cyc();
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL s1_drain got=%b exp=0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_reset_midstream();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
